// File: rtl/fc_irq_bridge.sv
// fc_irq_bridge: latches up to NB_IRQ interrupt lines (per-line edge or level
// mode, maskable), picks the lowest pending enabled ID and presents it to the
// FC core both as a req/id/ack handshake and as a one-hot irq_x vector.
// Optional macro FC_IRQ_BRIDGE_SYNC_EN adds a 2-flop synchroniser on irq_i.
//
// Handshake: core_irq_req_o and core_irq_id_o are held stable from the cycle
// req rises until the core returns a single-cycle core_irq_ack_i whose
// core_irq_ack_id_i equals core_irq_id_o. Only a matching ack completes the
// request. Any other ack, or an ack with no request open, raises ack_err_o
// for one cycle. After a completed request, req stays low for at least one
// bubble cycle before the next request can appear.
module fc_irq_bridge #(
    parameter int NB_IRQ = 32,
    parameter logic [NB_IRQ-1:0] RESET_MASK = '1,
    localparam int ID_WIDTH = $clog2(NB_IRQ)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NB_IRQ-1:0]   irq_i,
    input  logic [NB_IRQ-1:0]   irq_edge_i,
    input  logic                mask_we_i,
    input  logic [NB_IRQ-1:0]   mask_wdata_i,
    output logic [NB_IRQ-1:0]   mask_o,
    output logic [NB_IRQ-1:0]   pending_o,
    output logic                core_irq_req_o,
    output logic [ID_WIDTH-1:0] core_irq_id_o,
    input  logic                core_irq_ack_i,
    input  logic [ID_WIDTH-1:0] core_irq_ack_id_i,
    output logic [NB_IRQ-1:0]   irq_x_o,
    output logic                ack_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [NB_IRQ-1:0] ONE_HOT0 = {{(NB_IRQ-1){1'b0}}, 1'b1};

    state_e              state_q;
    logic [NB_IRQ-1:0]   irq_s;
    logic [NB_IRQ-1:0]   irq_q;
    logic [NB_IRQ-1:0]   pending_q;
    logic [NB_IRQ-1:0]   mask_q;
    logic [NB_IRQ-1:0]   set_v;
    logic [NB_IRQ-1:0]   clr_v;
    logic                req_q;
    logic [ID_WIDTH-1:0] id_q;
    logic                ack_err_q;
    logic                ack_hit;
    logic                cand_valid;
    logic [ID_WIDTH-1:0] cand_id;

`ifdef FC_IRQ_BRIDGE_SYNC_EN
    logic [NB_IRQ-1:0] sync1_q;
    logic [NB_IRQ-1:0] sync2_q;

    // Two-flop synchroniser for asynchronous interrupt sources.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_i;
`endif

    // A completed request clears exactly the acknowledged line.
    assign ack_hit = (state_q == REQ) && core_irq_ack_i && (core_irq_ack_id_i == id_q);
    assign clr_v   = ack_hit ? (ONE_HOT0 << id_q) : '0;
    // Edge lines set on a 0->1 transition, level lines set while high.
    assign set_v   = (irq_edge_i & irq_s & ~irq_q) | (~irq_edge_i & irq_s);

    // Previous-cycle sample, pending latch (set beats clear) and mask register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= RESET_MASK;
        end else begin
            irq_q     <= irq_s;
            pending_q <= (pending_q & ~clr_v) | set_v;
            if (mask_we_i) begin
                mask_q <= mask_wdata_i;
            end
        end
    end

    // Fixed-priority pick: lowest index that is both pending and enabled.
    always_comb begin
        cand_valid = 1'b0;
        cand_id    = '0;
        for (int k = NB_IRQ - 1; k >= 0; k--) begin
            if (pending_q[k] && mask_q[k]) begin
                cand_valid = 1'b1;
                cand_id    = ID_WIDTH'(k);
            end
        end
    end

    // Request FSM; req, id and ack_err are registered here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            id_q      <= '0;
            ack_err_q <= 1'b0;
        end else begin
            ack_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (core_irq_ack_i) begin
                        ack_err_q <= 1'b1;
                    end
                    if (cand_valid) begin
                        id_q    <= cand_id;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (ack_hit) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT;
                    end else begin
                        if (core_irq_ack_i) begin
                            ack_err_q <= 1'b1;
                        end
                        // Line masked under an open request: withdraw it, keep pending.
                        if (!mask_q[id_q]) begin
                            req_q   <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                WAIT: begin
                    if (core_irq_ack_i) begin
                        ack_err_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mask_o         = mask_q;
    assign pending_o      = pending_q;
    assign core_irq_req_o = req_q;
    assign core_irq_id_o  = id_q;
    assign ack_err_o      = ack_err_q;
    assign irq_x_o        = req_q ? (ONE_HOT0 << id_q) : '0;

endmodule

// File: tb/tb_fc_irq_bridge.sv
// Bench for fc_irq_bridge: directed scenarios plus random traffic on a
// 32-line instance checked every cycle against a behavioural model, and a
// short directed check of a 64-line instance.
module tb_fc_irq_bridge;

    localparam int NB = 32;
    localparam int IW = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- 32-line DUT ----------------
    logic [NB-1:0] irq, irq_edge, mask_wdata, mask_o, pending_o, irq_x_o;
    logic          mask_we, req_o, ack, ack_err_o;
    logic [IW-1:0] id_o, ack_id;

    fc_irq_bridge #(.NB_IRQ(NB)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .irq_i(irq), .irq_edge_i(irq_edge),
        .mask_we_i(mask_we), .mask_wdata_i(mask_wdata),
        .mask_o(mask_o), .pending_o(pending_o),
        .core_irq_req_o(req_o), .core_irq_id_o(id_o),
        .core_irq_ack_i(ack), .core_irq_ack_id_i(ack_id),
        .irq_x_o(irq_x_o), .ack_err_o(ack_err_o)
    );

    // ---------------- 64-line DUT ----------------
    logic [63:0] irq64, edge64, mwd64, mask64, pend64, irqx64;
    logic        mwe64, req64, ack64, err64;
    logic [5:0]  id64, ackid64;

    fc_irq_bridge #(.NB_IRQ(64)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n),
        .irq_i(irq64), .irq_edge_i(edge64),
        .mask_we_i(mwe64), .mask_wdata_i(mwd64),
        .mask_o(mask64), .pending_o(pend64),
        .core_irq_req_o(req64), .core_irq_id_o(id64),
        .core_irq_ack_i(ack64), .core_irq_ack_id_i(ackid64),
        .irq_x_o(irqx64), .ack_err_o(err64)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Served request: m_req/m_id. After a completed request m_gap holds off
    // the next pick for one cycle.
    logic [NB-1:0] m_prev, m_pend, m_mask, m_s1, m_s2;
    bit            m_req, m_gap, m_err;
    int            m_id;

    function automatic int lowest(input logic [NB-1:0] v);
        for (int k = 0; k < NB; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_prev = '0; m_pend = '0; m_mask = '1; m_s1 = '0; m_s2 = '0;
        m_req = 0; m_gap = 0; m_err = 0; m_id = 0;
    endtask

    task automatic model_step();
        logic [NB-1:0] inp, set_v, clr_v;
        bit ack_ok;
        int k;
`ifdef FC_IRQ_BRIDGE_SYNC_EN
        inp = m_s2; m_s2 = m_s1; m_s1 = irq;
`else
        inp = irq;
`endif
        for (int b = 0; b < NB; b++)
            set_v[b] = irq_edge[b] ? (inp[b] & ~m_prev[b]) : inp[b];
        clr_v = '0;
        ack_ok = ack && m_req && (int'(ack_id) == m_id);
        m_err = ack && !ack_ok;
        if (ack_ok) begin
            clr_v[m_id] = 1'b1;
            m_req = 0;
            m_gap = 1;
        end else if (m_req) begin
            if (!m_mask[m_id]) m_req = 0;
        end else if (m_gap) begin
            m_gap = 0;
        end else begin
            k = lowest(m_pend & m_mask);
            if (k >= 0) begin
                m_req = 1;
                m_id = k;
            end
        end
        m_pend = (m_pend & ~clr_v) | set_v;
        if (mask_we) m_mask = mask_wdata;
        m_prev = inp;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- compare process ----------------
    initial begin
        logic [NB-1:0] one;
        forever begin
            @(negedge clk);
            one = 1;
            check("pending", 64'(pending_o), 64'(m_pend));
            check("mask", 64'(mask_o), 64'(m_mask));
            check("req", 64'(req_o), 64'(m_req));
            check("id", 64'(id_o), 64'(IW'(m_id)));
            check("irq_x", 64'(irq_x_o), m_req ? 64'(one << m_id) : 64'd0);
            check("ack_err", 64'(ack_err_o), 64'(m_err));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_ack(input int id);
        ack = 1'b1;
        ack_id = IW'(id);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        irq = '0; irq_edge = '1; mask_we = 0; mask_wdata = '0; ack = 0; ack_id = '0;
        irq64 = '0; edge64 = '1; mwe64 = 0; mwd64 = '0; ack64 = 0; ackid64 = '0;
        #1 rst_n = 1'b0;
        tick(); tick();
        check("rst_pending", 64'(pending_o), 64'd0);
        check("rst_mask", 64'(mask_o), 64'hFFFF_FFFF);
        check("rst_req", 64'(req_o), 64'd0);
        check("rst_irqx", 64'(irq_x_o), 64'd0);
        rst_n = 1'b1;
        tick(); tick();

        // Single edge-mode line.
        irq[5] = 1'b1;
        tick();
        check("t1_pending", 64'(pending_o), 64'h20);
        check("t1_req_early", 64'(req_o), 64'd0);
        tick();
        check("t1_req", 64'(req_o), 64'd1);
        check("t1_id", 64'(id_o), 64'd5);
        check("t1_irqx", 64'(irq_x_o), 64'h20);
        do_ack(5);
        tick(); ack = 0;
        check("t1_req_drop", 64'(req_o), 64'd0);
        check("t1_pend_clr", 64'(pending_o), 64'd0);

        // Simultaneous lines 3 and 9: 3 first, 9 three cycles after the ack.
        irq = (NB'(1) << 3) | (NB'(1) << 9);
        tick(); tick();
        check("t2_id3", 64'(id_o), 64'd3);
        do_ack(3);
        tick(); ack = 0;
        check("t2_gap1", 64'(req_o), 64'd0);
        tick();
        check("t2_gap2", 64'(req_o), 64'd0);
        tick();
        check("t2_req9", 64'(req_o), 64'd1);
        check("t2_id9", 64'(id_o), 64'd9);

        // No preemption by higher-priority line 1.
        irq[1] = 1'b1;
        tick(); tick();
        check("t3_hold9", 64'(id_o), 64'd9);
        check("t3_pend", 64'(pending_o), 64'h202);
        do_ack(9);
        tick(); ack = 0;
        tick(); tick();
        check("t3_id1", 64'(id_o), 64'd1);
        check("t3_req1", 64'(req_o), 64'd1);
        do_ack(1);
        tick(); ack = 0;
        tick();

        // Mismatched ack, then ack while idle.
        irq[7] = 1'b1;
        tick(); tick();
        check("t4_id7", 64'(id_o), 64'd7);
        do_ack(4);
        tick(); ack = 0;
        check("t4_err", 64'(ack_err_o), 64'd1);
        check("t4_req_held", 64'(req_o), 64'd1);
        check("t4_pend7", 64'(pending_o[7]), 64'd1);
        tick();
        check("t4_err_pulse", 64'(ack_err_o), 64'd0);
        do_ack(7);
        tick(); ack = 0;
        tick();
        do_ack(0);
        tick(); ack = 0;
        check("t4_idle_err", 64'(ack_err_o), 64'd1);
        check("t4_idle_req", 64'(req_o), 64'd0);

        // Level line 2 held high through ack, then masked.
        irq_edge[2] = 1'b0;
        irq[2] = 1'b1;
        tick(); tick();
        check("t5_id2", 64'(id_o), 64'd2);
        do_ack(2);
        tick(); ack = 0;
        check("t5_repend", 64'(pending_o[2]), 64'd1);
        check("t5_drop", 64'(req_o), 64'd0);
        tick(); tick();
        check("t5_rereq", 64'(req_o), 64'd1);
        check("t5_reid", 64'(id_o), 64'd2);
        mask_we = 1; mask_wdata = ~(NB'(1) << 2);
        tick(); mask_we = 0;
        check("t5_mask", 64'(mask_o), 64'hFFFF_FFFB);
        tick();
        check("t5_mask_drop", 64'(req_o), 64'd0);
        check("t5_mask_keep", 64'(pending_o[2]), 64'd1);
        irq[2] = 1'b0;
        mask_we = 1; mask_wdata = 32'h0000_FFFF;
        tick(); mask_we = 0;
        tick();
        check("t6_req", 64'(req_o), 64'd1);
        check("t6_id", 64'(id_o), 64'd2);

        // Asynchronous reset in the middle of a request.
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_req", 64'(req_o), 64'd0);
        check("t6_rst_id", 64'(id_o), 64'd0);
        check("t6_rst_irqx", 64'(irq_x_o), 64'd0);
        check("t6_rst_pend", 64'(pending_o), 64'd0);
        check("t6_rst_mask", 64'(mask_o), 64'hFFFF_FFFF);
        tick();
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (c % 200 == 0) irq_edge = $urandom;
            irq = $urandom & $urandom & $urandom;
            mask_we = ($urandom_range(0, 19) == 0);
            mask_wdata = $urandom | $urandom;
            if ($urandom_range(0, 9) < 4) begin
                if (m_req && $urandom_range(0, 3) != 0) do_ack(m_id);
                else do_ack(int'($urandom_range(0, NB - 1)));
            end else begin
                ack = 0;
            end
        end
        tick();
        irq = '0; ack = 0; mask_we = 0;
        tick();

        // 64-line instance: top line.
        irq64[63] = 1'b1;
        tick();
        check("w64_pend", pend64, 64'h8000_0000_0000_0000);
        tick();
        check("w64_req", 64'(req64), 64'd1);
        check("w64_id", 64'(id64), 64'd63);
        check("w64_irqx", irqx64, 64'h8000_0000_0000_0000);
        ack64 = 1; ackid64 = 6'd63;
        tick(); ack64 = 0;
        check("w64_drop", 64'(req64), 64'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_irq_bridge.md
Name: fc_irq_bridge

Overview:
Parametrised interrupt bridge between the FC event unit / peripheral IRQ lines and the FC core.
- Latches up to NB_IRQ interrupt lines, per-line edge or level mode, with masking.
- Arbitrates pending lines by fixed priority (lowest ID wins).
- Presents both interfaces: RI5CY-style req/id/ack handshake and an Ibex-style one-hot irq_x vector.
- Successor to the fixed 32-line ID-to-line conversion in the FC subsystem. Adds pending storage, ack-ID checking and a configurable line count.

Parameters:
- NB_IRQ, 32, number of interrupt lines; legal range 2..64.
- ID_WIDTH, $clog2(NB_IRQ), width of interrupt ID fields; derived, not overridden.
- RESET_MASK, '1, reset value of the internal mask register (1 = line enabled).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- irq_i  in  NB_IRQ  raw interrupt lines
- irq_edge_i  in  NB_IRQ  per-line mode: 1 = rising-edge, 0 = level
- mask_we_i  in  1  write strobe for mask register
- mask_wdata_i  in  NB_IRQ  new mask value
- mask_o  out  NB_IRQ  current mask register
- pending_o  out  NB_IRQ  pending register
- core_irq_req_o  out  1  request to core
- core_irq_id_o  out  ID_WIDTH  ID of requested interrupt
- core_irq_ack_i  in  1  core acknowledge, single-cycle pulse
- core_irq_ack_id_i  in  ID_WIDTH  ID being acknowledged
- irq_x_o  out  NB_IRQ  one-hot of core_irq_id_o while core_irq_req_o = 1, else 0
- ack_err_o  out  1  one-cycle pulse on ack with mismatched ID or ack while IDLE

Behaviour:
- Reset (rst_ni low, asynchronous):
  - irq_q, pending, req, id, ack_err all cleared to 0.
  - mask = RESET_MASK.
  - FSM = IDLE.
- Sampling: irq_q <= irq_i every cycle.
- Set condition for line k:
  - edge mode: irq_i[k] & ~irq_q[k].
  - level mode: irq_i[k].
- Pending update:
  - pending[k] <= (pending[k] & ~clr[k]) | set[k].
  - Set wins over a same-cycle clear.
  - Masked lines still latch pending but are not arbitrated.
- Mask write: mask takes mask_wdata_i the cycle after mask_we_i. Masking a line does not clear its pending bit.
- Arbiter: candidate = lowest index k with pending[k] & mask[k]. Combinational from registered state.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: if a candidate exists, register id <= candidate, req <= 1, go to REQ. Latency: irq_i rising at edge N -> pending at N+1 -> core_irq_req_o at N+2.
  - REQ:
    - req and id are held stable until ack, even if a higher-priority line becomes pending. No preemption.
    - On core_irq_ack_i with ack_id == id: clr[id] = 1, req <= 0, go to WAIT.
    - On core_irq_ack_i with ack_id != id: ack_err_o pulses next cycle; pending unchanged; stay in REQ.
    - If the requested line gets masked while in REQ: req <= 0, back to IDLE, pending kept.
  - WAIT: one bubble cycle so the core's irq view drops before the next request. Then go to IDLE.
  - Back-to-back throughput: one interrupt per 3 cycles minimum.
- Level mode: a line still high after clear re-pends on the next cycle. This is intended; software must clear the source.
- core_irq_ack_i while IDLE or WAIT: ack_err_o pulses; no state change.
- ID arithmetic: ID_WIDTH bits, zero-extended. ack_id >= NB_IRQ counts as a mismatch.

Optional Feature:
FC_IRQ_BRIDGE_SYNC_EN
- Defined: irq_i passes through a 2-flop synchroniser (reset 0) before irq_q and edge detection. Set-to-request latency becomes 4 cycles.
- Undefined: irq_i is assumed synchronous to clk_i. Latency is 2 cycles as above.

Test Plan:
- Reset then irq_i[5]=1 (edge mode) at cycle 0 -> pending_o[5]=1 at cycle 1; req=1, id=5, irq_x_o=32'h20 at cycle 2. Ack id 5 -> req=0 next cycle; pending_o=0.
- irq_i[3] and irq_i[9] rise in the same cycle -> id=3 first. After ack and the WAIT bubble, id=9 appears exactly 3 cycles after the first ack.
- While req with id=9, irq_i[1] rises -> id stays 9 until acked; then id=1 is served.
- Ack with ack_id=4 while id=7 -> ack_err_o one-cycle pulse, req stays high, pending_o[7] stays 1. Ack while IDLE -> ack_err_o pulse.
- Level-mode line 2 held high through ack -> pending re-sets; req reasserts with id=2 after the bubble. Mask line 2 via mask_we_i -> req drops, pending_o[2] stays 1.
- Assert rst_ni low mid-REQ -> all outputs 0 immediately and mask = RESET_MASK. With NB_IRQ=64, line 63 -> id=6'd63, irq_x_o[63]=1.
